bcd_seq_ctrl: RTL and testbench
===============================

// Module: bcd_seq_ctrl
// PURPOSE
//  Multi-cycle binary-to-BCD converter with its sequencing FSM and valid/ready handshakes.
//  Runs the shift/add-3 (double-dabble) datapath one input bit per clock.
//  Sits between the multiplier product output and the decimal display/readout logic.
//  Replaces the unrolled combinational converter where area or timing matters.
// PARAMETERS
//  WIDTH   8   binary input width in bits (>=1)
//  DIGITS  3   number of BCD output digits (4 bits each)
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            synchronous reset, active-low
//  in_valid   in   1            in_data valid
//  in_ready   out  1            converter can accept a new operand
//  in_data    in   WIDTH        unsigned binary operand
//  out_valid  out  1            out_bcd/overflow hold a finished result
//  out_ready  in   1            consumer accepts result
//  out_bcd    out  4*DIGITS     packed BCD; [3:0]=ones, [7:4]=tens, ...
//  overflow   out  1            value did not fit in DIGITS digits
//  busy       out  1            conversion in progress or result pending
// BEHAVIOUR
//  - Reset (rst_n low at rising edge): state=IDLE; out_bcd=0, overflow=0, out_valid=0,
//    busy=0, in_ready=1 after the edge. Any conversion in flight is discarded.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE:  in_ready=1. On in_valid&&in_ready, do the following, then go to SHIFT:
//           latch in_data into the shift register.
//           clear the BCD accumulator and overflow.
//           load the bit counter with WIDTH.
//    SHIFT: each cycle, first add 3 to every digit >=5.
//           then shift {bcd,shreg} left 1; the shreg MSB enters ones[0].
//           a 1 shifted out of the top digit sets overflow (sticky).
//           decrement the counter; after the WIDTH-th shift, go to DONE.
//    DONE:  out_valid=1. Go to IDLE on out_ready.
//  - in_ready = (state==IDLE); busy = (state!=IDLE). in_valid is ignored while busy.
//  - Latency: out_valid rises exactly WIDTH edges after the accepting edge.
//  - Throughput: min WIDTH+2 cycles per conversion: accept, WIDTH shifts, result handshake.
//    With out_ready tied high, the next accept occurs in the IDLE cycle after DONE.
//  - Backpressure: out_bcd and overflow hold stable while out_valid && !out_ready.
//  - out_bcd shows the accumulator. It is meaningful only when out_valid=1.
//    It keeps the last result after the handshake, until the next accept clears it.
//  - Counter width is $clog2(WIDTH+1). There are no wrap-around states.
//  - Illegal or unused state encodings return to IDLE.
//  - Digits never exceed 9 at out_valid when overflow=0.
// TESTING
//  1. in_data=8'd255, out_ready=1 -> out_valid exactly 8 cycles after accept.
//     Expect out_bcd=12'h255, overflow=0.
//  2. in_data=8'd0 -> out_bcd=12'h000; in_data=8'd9 -> 12'h009; in_data=8'd100 -> 12'h100.
//  3. Hold out_ready=0 for 5 cycles with result 8'd137.
//     out_bcd holds 12'h137, in_ready=0, busy=1.
//     Release out_ready -> IDLE next edge.
//  4. Pulse in_valid with 8'd42 during SHIFT of 8'd200.
//     Expect result 12'h200, and 42 is never converted.
//  5. Drop rst_n for 1 cycle mid-SHIFT -> next cycle in_ready=1, out_valid=0, out_bcd=0.
//     A fresh 8'd77 then yields 12'h077.
//  6. DIGITS=2 build, in_data=8'd100 -> overflow=1. Exhaustive 0..255 (DIGITS=3), back-to-back
//     with random out_ready, checked against a /10 %10 model.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, with
// valid/ready handshakes on both sides and a sticky overflow flag.
module bcd_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [BW-1:0]     bcd_q;
    logic [WIDTH-1:0]  shreg_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              out_valid_q;

    logic [BW-1:0]     adj_d;
    logic [BW-1:0]     bcd_d;
    logic [WIDTH-1:0]  shreg_d;
    logic              carry_d;

    // Add 3 to every digit that is 5 or more, so the following doubling carries in decimal.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // One double-dabble step: correct digits, then shift {bcd, shreg} left by one.
    always_comb begin
        adj_d              = add3_digits(bcd_q);
        {carry_d, bcd_d}   = {adj_d, shreg_q[WIDTH-1]};
        shreg_d            = shreg_q << 1;
    end

    // Sequencing FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q    <= in_data;
                        bcd_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= CW'(WIDTH);
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_d;
                    bcd_q   <= bcd_d;
                    ovf_q   <= ovf_q | carry_d;
                    cnt_q   <= cnt_q - CW'(1);
                    // The last shift lands the result; announce it on the same edge.
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = bcd_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: a DIGITS=3 instance plus a DIGITS=2 instance
// driven in lockstep for overflow checks.
module tb_bcd_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        in_ready, out_valid, overflow, busy;
    logic [11:0] out_bcd;
    logic        in_ready2, out_valid2, overflow2, busy2;
    logic [7:0]  out_bcd2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .overflow(overflow), .busy(busy)
    );

    bcd_seq_ctrl #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_bcd(out_bcd2), .overflow(overflow2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] model(input int v);
        logic [11:0] r;
        r[3:0]  = 4'((v) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic start(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        int lat;
        logic hs;
        int guard;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_bcd",       {20'd0, out_bcd},   32'd0);
        check("rst_ovf",       {31'd0, overflow},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 255 with out_ready high: latency and value.
        start(8'd255);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_valid(lat);
        check("lat_255",  lat, 32'd8);
        check("bcd_255",  {20'd0, out_bcd}, 32'h255);
        check("ovf_255",  {31'd0, overflow}, 32'd0);
        check("ovf2_255", {31'd0, overflow2}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("idle_after_255", {31'd0, in_ready}, 32'd1);

        // Small directed values.
        start(8'd0);   wait_valid(lat); check("bcd_0",   {20'd0, out_bcd}, 32'h000);
        @(posedge clk); @(negedge clk);
        start(8'd9);   wait_valid(lat); check("bcd_9",   {20'd0, out_bcd}, 32'h009);
        @(posedge clk); @(negedge clk);
        start(8'd100); wait_valid(lat); check("bcd_100", {20'd0, out_bcd}, 32'h100);
        check("ovf_100",  {31'd0, overflow},  32'd0);
        check("ovf2_100", {31'd0, overflow2}, 32'd1);
        @(posedge clk); @(negedge clk);

        // Backpressure with 137.
        out_ready = 1'b0;
        start(8'd137);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check("hold_bcd",      {20'd0, out_bcd},   32'h137);
            check("hold_in_ready", {31'd0, in_ready},  32'd0);
            check("hold_busy",     {31'd0, busy},      32'd1);
            check("hold_valid",    {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready},  32'd1);
        check("release_valid",    {31'd0, out_valid}, 32'd0);
        check("release_busy",     {31'd0, busy},      32'd0);
        check("keep_last_bcd",    {20'd0, out_bcd},   32'h137);

        // in_valid pulse during a conversion is ignored.
        start(8'd200);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b1; in_data = 8'd42;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("lat_200", lat, 32'd5);
        check("bcd_200", {20'd0, out_bcd}, 32'h200);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
        end
        check("no_42_valid", {31'd0, out_valid}, 32'd0);
        check("no_42_bcd",   {20'd0, out_bcd},   32'h200);

        // Reset mid-conversion.
        start(8'd99);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        check("mrst_in_ready", {31'd0, in_ready},  32'd1);
        check("mrst_valid",    {31'd0, out_valid}, 32'd0);
        check("mrst_bcd",      {20'd0, out_bcd},   32'd0);
        check("mrst_busy",     {31'd0, busy},      32'd0);
        start(8'd77);
        wait_valid(lat);
        check("bcd_77", {20'd0, out_bcd}, 32'h077);
        @(posedge clk); @(negedge clk);

        // Exhaustive sweep with random result backpressure.
        for (int v = 0; v < 256; v++) begin
            check("sweep_in_ready", {31'd0, in_ready}, 32'd1);
            start(8'(v));
            wait_valid(lat);
            check("sweep_bcd",  {20'd0, out_bcd},   {20'd0, model(v)});
            check("sweep_ovf",  {31'd0, overflow},  32'd0);
            check("sweep_ovf2", {31'd0, overflow2}, {31'd0, (v >= 100)});
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_ready;
                @(posedge clk);
                @(negedge clk);
                guard++;
            end
            check("sweep_handshake", {31'd0, out_valid}, 32'd0);
            out_ready = 1'b1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
